// File: rtl/vend_credit_ctrl.sv
// -----------------------------------------------------------------------------
// vend_credit_ctrl
//
// Credit and change controller for a single-price vending machine. Coins add
// credit in whole units. A purchase request with enough credit dispenses the
// item for one cycle. Any remainder is then offered as change. Cancel refunds
// the whole credit through the same change handshake. The credit is also shown
// in cents as two registered BCD digits.
//
// Ports
//   clk           : single clock, all state updates on the rising edge
//   rst_n         : asynchronous active-low reset
//   coin_valid    : a coin is present this cycle
//   coin_units    : value of the coin in credit units
//   vend_req      : purchase request
//   cancel        : refund request
//   change_ack    : change dispenser has taken the pending change
//   coin_ready    : coin acceptance permitted (IDLE / CREDIT)
//   reject        : one-cycle pulse, the previously offered coin is returned
//   credit        : current credit in units
//   digit_tens    : BCD tens digit of credit*UNIT_CENTS (one cycle behind)
//   digit_ones    : BCD ones digit of credit*UNIT_CENTS (one cycle behind)
//   vend_pulse    : one-cycle pulse, dispense the item
//   change_valid  : change pending
//   change_units  : change amount in units, valid while change_valid
// -----------------------------------------------------------------------------
module vend_credit_ctrl #(
    parameter int UNIT_CENTS  = 5,
    parameter int MAX_UNITS   = 12,
    parameter int CW          = 4,
    parameter int PRICE_UNITS = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coin_valid,
    input  logic [2:0]    coin_units,
    input  logic          vend_req,
    input  logic          cancel,
    input  logic          change_ack,
    output logic          coin_ready,
    output logic          reject,
    output logic [CW-1:0] credit,
    output logic [3:0]    digit_tens,
    output logic [3:0]    digit_ones,
    output logic          vend_pulse,
    output logic          change_valid,
    output logic [CW-1:0] change_units
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CREDIT = 2'd1;
    localparam logic [1:0] ST_VEND   = 2'd2;
    localparam logic [1:0] ST_CHANGE = 2'd3;

    logic [1:0]    state_q,        state_d;
    logic [CW-1:0] credit_q,       credit_d;
    logic [CW-1:0] change_units_q, change_units_d;
    logic          reject_q,       reject_d;
    logic [3:0]    digit_tens_q,   digit_tens_d;
    logic [3:0]    digit_ones_q,   digit_ones_d;

    logic          coin_offered;
    logic [CW:0]   coin_sum;
    logic          coin_fits;
    logic          can_vend;
    logic [CW-1:0] vend_rem;
    logic [6:0]    cents;

    // The sum carries one extra bit so an overflowing coin cannot wrap
    // around and slip under the MAX_UNITS compare.
    assign coin_offered = coin_valid && (coin_units != 3'd0);
    assign coin_sum     = {1'b0, credit_q} + (CW+1)'(coin_units);
    assign coin_fits    = coin_sum <= (CW+1)'(MAX_UNITS);
    assign can_vend     = credit_q >= CW'(PRICE_UNITS);
    assign vend_rem     = credit_q - CW'(PRICE_UNITS);

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_units_d = change_units_q;
        reject_d       = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                // Priority is cancel > vend_req > coin. Cancel and vend are
                // only honoured in CREDIT. A coin arriving with an accepted
                // cancel or vend is returned.
                if (cancel && (state_q == ST_CREDIT)) begin
                    state_d        = ST_CHANGE;
                    change_units_d = credit_q;
                    credit_d       = '0;
                    reject_d       = coin_offered;
                end else if (vend_req && (state_q == ST_CREDIT) && can_vend) begin
                    state_d  = ST_VEND;
                    reject_d = coin_offered;
                end else if (coin_offered) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CW-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end

            ST_VEND: begin
                // Credit is still displayed during the dispense cycle. It is
                // cleared only as the machine leaves VEND.
                reject_d = coin_offered;
                credit_d = '0;
                if (vend_rem != '0) begin
                    state_d        = ST_CHANGE;
                    change_units_d = vend_rem;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CHANGE: begin
                reject_d = coin_offered;
                if (change_ack) begin
                    state_d        = ST_IDLE;
                    change_units_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Display path: the digits are taken from the registered credit, so they
    // follow a credit change by one cycle. UNIT_CENTS*MAX_UNITS <= 99 keeps the
    // value inside 7 bits.
    always_comb begin
        cents        = 7'(int'(credit_q) * UNIT_CENTS);
        digit_tens_d = 4'(cents / 7'd10);
        digit_ones_d = 4'(cents % 7'd10);
    end

    // NOTE: sequential state uses non-blocking assignments only. Every flop
    // updates from values sampled before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_units_q <= '0;
            reject_q       <= 1'b0;
            digit_tens_q   <= 4'd0;
            digit_ones_q   <= 4'd0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_units_q <= change_units_d;
            reject_q       <= reject_d;
            digit_tens_q   <= digit_tens_d;
            digit_ones_q   <= digit_ones_d;
        end
    end

    // These outputs are decoded from the state register. Reset therefore
    // clears them at once and drops any pending vend or change.
    assign coin_ready   = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
    assign vend_pulse   = (state_q == ST_VEND);
    assign change_valid = (state_q == ST_CHANGE);
    assign change_units = change_units_q;
    assign reject       = reject_q;
    assign credit       = credit_q;
    assign digit_tens   = digit_tens_q;
    assign digit_ones   = digit_ones_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_credit_ctrl
//
// Self-checking bench for vend_credit_ctrl at default parameters (5c units,
// 12-unit maximum, price 9 units). Each table row is one clock cycle. It holds
// the inputs driven before the edge and the outputs expected just after it.
// Expected rows enter a scoreboard queue when driven and are compared when the
// cycle completes. Reset behaviour is exercised by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [2:0] coin_units;
    logic       vend_req;
    logic       cancel;
    logic       change_ack;
    logic       coin_ready;
    logic       reject;
    logic [3:0] credit;
    logic [3:0] digit_tens;
    logic [3:0] digit_ones;
    logic       vend_pulse;
    logic       change_valid;
    logic [3:0] change_units;

    int n_checks = 0;
    int n_fail   = 0;

    vend_credit_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_units   (coin_units),
        .vend_req     (vend_req),
        .cancel       (cancel),
        .change_ack   (change_ack),
        .coin_ready   (coin_ready),
        .reject       (reject),
        .credit       (credit),
        .digit_tens   (digit_tens),
        .digit_ones   (digit_ones),
        .vend_pulse   (vend_pulse),
        .change_valid (change_valid),
        .change_units (change_units)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cv;
        logic [2:0] cu;
        logic       vr;
        logic       cn;
        logic       ack;
        logic [3:0] e_credit;
        logic [3:0] e_tens;
        logic [3:0] e_ones;
        logic       e_rej;
        logic       e_vend;
        logic       e_cvld;
        logic [3:0] e_cu;
        logic       e_rdy;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic cv, input logic [2:0] cu,
                                input logic vr, input logic cn, input logic ack,
                                input logic [3:0] e_credit, input logic [3:0] e_tens,
                                input logic [3:0] e_ones, input logic e_rej,
                                input logic e_vend, input logic e_cvld,
                                input logic [3:0] e_cu, input logic e_rdy);
        vec_t v;
        v.cv = cv; v.cu = cu; v.vr = vr; v.cn = cn; v.ack = ack;
        v.e_credit = e_credit; v.e_tens = e_tens; v.e_ones = e_ones;
        v.e_rej = e_rej; v.e_vend = e_vend; v.e_cvld = e_cvld;
        v.e_cu = e_cu; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        coin_valid = 1'b0;
        coin_units = 3'd0;
        vend_req   = 1'b0;
        cancel     = 1'b0;
        change_ack = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " credit"},       credit,       0);
        check({tag, " digit_tens"},   digit_tens,   0);
        check({tag, " digit_ones"},   digit_ones,   0);
        check({tag, " vend_pulse"},   vend_pulse,   0);
        check({tag, " change_valid"}, change_valid, 0);
        check({tag, " change_units"}, change_units, 0);
        check({tag, " reject"},       reject,       0);
    endtask

    initial begin
        vec_t exp_v;
        string tag;

        rst_n = 1'b0;
        drive_idle();

        // Columns: cv cu vr cn ack | credit tens ones rej vend cvld cu rdy
        // Exact price: 5+2+2 = 9 units, vend, no change.
        vecs.push_back(mk(1,5,0,0,0,  5,0,0,0,0,0, 0,1));
        vecs.push_back(mk(1,2,0,0,0,  7,2,5,0,0,0, 0,1));
        vecs.push_back(mk(1,2,0,0,0,  9,3,5,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,0,  9,4,5,0,0,0, 0,1));
        vecs.push_back(mk(0,0,1,0,0,  9,4,5,0,1,0, 0,0));
        vecs.push_back(mk(0,0,0,0,0,  0,4,5,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,0, 0,1));
        // Change: 5+5+1 = 11, overflow coin rejected, vend, 2 units of change.
        vecs.push_back(mk(1,5,0,0,0,  5,0,0,0,0,0, 0,1));
        vecs.push_back(mk(1,5,0,0,0, 10,2,5,0,0,0, 0,1));
        vecs.push_back(mk(1,1,0,0,0, 11,5,0,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,0, 11,5,5,0,0,0, 0,1));
        vecs.push_back(mk(1,5,0,0,0, 11,5,5,1,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,0, 11,5,5,0,0,0, 0,1));
        vecs.push_back(mk(0,0,1,0,0, 11,5,5,0,1,0, 0,0));
        vecs.push_back(mk(1,1,0,0,0,  0,5,5,1,0,1, 2,0));
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,1, 2,0));
        vecs.push_back(mk(0,0,1,1,0,  0,0,0,0,0,1, 2,0));
        vecs.push_back(mk(0,0,0,0,1,  0,0,0,0,0,0, 0,1));
        // Priority: credit 10, cancel+vend+coin together.
        vecs.push_back(mk(1,5,0,0,0,  5,0,0,0,0,0, 0,1));
        vecs.push_back(mk(1,5,0,0,0, 10,2,5,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,0, 10,5,0,0,0,0, 0,1));
        vecs.push_back(mk(1,1,1,1,0,  0,5,0,1,0,1,10,0));
        vecs.push_back(mk(0,0,0,0,0,  0,0,0,0,0,1,10,0));
        vecs.push_back(mk(0,0,0,0,1,  0,0,0,0,0,0, 0,1));
        // Ignored requests in IDLE, zero-value coin, vend below price.
        vecs.push_back(mk(0,0,1,0,0,  0,0,0,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,1,1,  0,0,0,0,0,0, 0,1));
        vecs.push_back(mk(1,0,0,0,0,  0,0,0,0,0,0, 0,1));
        vecs.push_back(mk(1,2,1,0,0,  2,0,0,0,0,0, 0,1));
        vecs.push_back(mk(1,1,1,0,0,  3,1,0,0,0,0, 0,1));
        vecs.push_back(mk(0,0,0,0,0,  3,1,5,0,0,0, 0,1));
        // Cancel at credit 3 leaves the machine in CHANGE for the reset test.
        vecs.push_back(mk(0,0,0,1,0,  0,1,5,0,0,1, 3,0));

        // Reset state.
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release coin_ready", coin_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            coin_valid = vecs[i].cv;
            coin_units = vecs[i].cu;
            vend_req   = vecs[i].vr;
            cancel     = vecs[i].cn;
            change_ack = vecs[i].ack;
            sb_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                check("scoreboard empty", 1, 0);
            end else begin
                exp_v = sb_q.pop_front();
                tag = $sformatf("v%0d", i);
                check({tag, " credit"},       credit,       exp_v.e_credit);
                check({tag, " digit_tens"},   digit_tens,   exp_v.e_tens);
                check({tag, " digit_ones"},   digit_ones,   exp_v.e_ones);
                check({tag, " reject"},       reject,       exp_v.e_rej);
                check({tag, " vend_pulse"},   vend_pulse,   exp_v.e_vend);
                check({tag, " change_valid"}, change_valid, exp_v.e_cvld);
                check({tag, " change_units"}, change_units, exp_v.e_cu);
                check({tag, " coin_ready"},   coin_ready,   exp_v.e_rdy);
            end
        end

        // Asynchronous reset in the middle of CHANGE (change_units = 3).
        @(negedge clk);
        drive_idle();
        #2;
        check("pre-reset change_valid", change_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("async release coin_ready", coin_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            tag = $sformatf("post-reset c%0d", i);
            check({tag, " vend_pulse"},   vend_pulse,   0);
            check({tag, " change_valid"}, change_valid, 0);
            check({tag, " credit"},       credit,       0);
        end

        check("scoreboard drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vend_credit_ctrl.md
VEND_CREDIT_CTRL -- requirements
Module: vend_credit_ctrl

Interface
REQ-001 Parameter UNIT_CENTS, default 5, meaning value in cents of one credit unit.
REQ-002 Parameter MAX_UNITS, default 12, meaning maximum credit in units; UNIT_CENTS*MAX_UNITS SHALL be <= 99.
REQ-003 Parameter CW, default 4, meaning credit/change width; 2^CW > MAX_UNITS SHALL hold.
REQ-004 Parameter PRICE_UNITS, default 9, meaning item price in units; 1 <= PRICE_UNITS <= MAX_UNITS SHALL hold.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 coin_valid  input  1  coin present this cycle.
REQ-008 coin_units  input  3  coin value in units (1 = 5c, 2 = 10c, 5 = 25c at default parameters).
REQ-009 vend_req  input  1  purchase request, sampled each cycle.
REQ-010 cancel  input  1  refund request, sampled each cycle.
REQ-011 change_ack  input  1  change dispenser has taken change.
REQ-012 coin_ready  output  1  coin acceptance permitted.
REQ-013 reject  output  1  one-cycle pulse; the offered coin is returned.
REQ-014 credit  output  CW  current credit in units.
REQ-015 digit_tens  output  4  BCD tens digit of credit*UNIT_CENTS.
REQ-016 digit_ones  output  4  BCD ones digit of credit*UNIT_CENTS.
REQ-017 vend_pulse  output  1  one-cycle pulse; dispense the item.
REQ-018 change_valid  output  1  change pending.
REQ-019 change_units  output  CW  change amount in units; valid while change_valid.

Function
REQ-020 The FSM SHALL have states IDLE (credit 0), CREDIT (credit > 0), VEND, and CHANGE.
REQ-021 coin_ready SHALL be 1 in IDLE/CREDIT and 0 in VEND/CHANGE.
REQ-022 A coin is offered when coin_valid=1; with coin_ready=1, no vend/cancel this cycle, and credit+coin_units <= MAX_UNITS, credit SHALL become credit+coin_units on the next edge (IDLE -> CREDIT).
REQ-023 An offered coin that would exceed MAX_UNITS, or that arrives in VEND/CHANGE or together with an accepted vend_req/cancel, SHALL leave credit unchanged and pulse reject the next cycle.
REQ-024 coin_units = 0 with coin_valid SHALL be ignored, with no reject.
REQ-025 vend_req in CREDIT with credit >= PRICE_UNITS SHALL move to VEND; vend_pulse SHALL be 1 for exactly that one VEND cycle.
REQ-026 vend_req with credit < PRICE_UNITS, or in IDLE, SHALL be ignored, with no state change.
REQ-027 On leaving VEND, rem = credit-PRICE_UNITS; credit SHALL become 0; rem > 0 -> CHANGE with change_units = rem; rem = 0 -> IDLE.
REQ-028 cancel in CREDIT SHALL move to CHANGE with change_units = credit and credit set to 0; cancel in IDLE SHALL be ignored.
REQ-029 Priority in one cycle SHALL be cancel > vend_req > coin.
REQ-030 In CHANGE, change_valid SHALL be held at 1 and change_units held stable until change_ack=1; the next state is then IDLE, with change_valid 0.
REQ-031 change_ack outside CHANGE, and vend_req/cancel in VEND/CHANGE, SHALL be ignored.
REQ-032 digit_tens/digit_ones SHALL be registered and SHALL reflect credit*UNIT_CENTS one cycle after credit changes (latency 1).
REQ-033 Arithmetic SHALL be unsigned; the sum SHALL be computed at CW+1 bits before the overflow compare, so there is no wrap-around.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE and clear these outputs to 0: credit, digits, coin-related pulses, vend_pulse, change_valid, change_units.
REQ-035 Reset during VEND or CHANGE SHALL discard the pending vend/change; no vend_pulse SHALL follow reset release.
REQ-036 coin_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-037 Reset test: rst_n=0 -> credit 0, digits 0/0, vend_pulse/change_valid/reject 0; release -> coin_ready 1.
REQ-038 Exact-price test: coins 5, 2, 2 -> credit 9, digits 4/5; vend_req -> vend_pulse 1 cycle -> IDLE, change_valid stays 0.
REQ-039 Change test: coins 5, 5, 1 -> credit 11, digits 5/5; vend_req -> vend_pulse, then change_valid=1 with change_units=2 held until change_ack, then IDLE.
REQ-040 Overflow test: at credit 11, coin 5 -> reject pulse, credit stays 11, digits 5/5.
REQ-041 Priority test: at credit 10, cancel+vend_req+coin 1 in the same cycle -> no vend_pulse, reject pulse, change_units=10.
REQ-042 Async reset test: rst_n=0 mid-CHANGE (change_units=3) -> change_valid 0 before the next edge; no later vend_pulse or change.
